decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32/RV64 base-integer decode stage. It decodes the incoming instruction combinationally
// and buffers the result in a small FIFO, so no combinational path runs from input to output.

package decode_pkg;
  typedef enum logic [3:0] {
    OP_IMM, OP, LOAD, STORE, LUI, AUIPC, JAL, JALR, BRANCH, UNKNOWN
  } opcode_t;
endpackage

module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output opcode_t         opcode,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    opcode_t         op;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  opcode_t         w_opcode;
  logic [31:0]     w_imm32;
  entry_t          w_entry;
  entry_t          w_head;
  logic            w_push;
  logic            w_pop;

  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  entry_t          r_mem [DEPTH];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every always_comb assigns its outputs a default first, so no path can infer a latch.
  always_comb begin
    w_opcode = UNKNOWN;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:2])
        5'b00100: w_opcode = OP_IMM;
        5'b01100: w_opcode = OP;
        5'b00000: w_opcode = LOAD;
        5'b01000: w_opcode = STORE;
        5'b01101: w_opcode = LUI;
        5'b00101: w_opcode = AUIPC;
        5'b11011: w_opcode = JAL;
        5'b11001: w_opcode = JALR;
        5'b11000: w_opcode = BRANCH;
        default:  w_opcode = UNKNOWN;
      endcase
    end
  end

  always_comb begin
    w_imm32 = '0;
    case (w_opcode)
      OP_IMM, LOAD, JALR: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      STORE:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      BRANCH: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
      LUI, AUIPC: w_imm32 = {in_instr[31:12], 12'b0};
      JAL:    w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  always_comb begin
    w_entry         = '0;
    w_entry.pc      = in_pc;
    w_entry.op      = w_opcode;
    w_entry.rs1     = in_instr[19:15];
    w_entry.rs2     = in_instr[24:20];
    w_entry.rd      = in_instr[11:7];
    w_entry.funct3  = in_instr[14:12];
    w_entry.funct7  = in_instr[31:25];
    w_entry.imm     = XLEN'($signed(w_imm32));
    w_entry.illegal = (w_opcode == UNKNOWN);
  end

  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

  // Reset and flush both empty the buffer; reset also wins over flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: the storage array has no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    out_pc  = '0;
    opcode  = UNKNOWN;
    rs1     = '0;
    rs2     = '0;
    rd      = '0;
    funct3  = '0;
    funct7  = '0;
    imm     = '0;
    illegal = 1'b0;
    if (out_valid) begin
      out_pc  = w_head.pc;
      opcode  = w_head.op;
      rs1     = w_head.rs1;
      rs2     = w_head.rs2;
      rd      = w_head.rd;
      funct3  = w_head.funct3;
      funct7  = w_head.funct7;
      imm     = w_head.imm;
      illegal = w_head.illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a 32-bit and a 64-bit instance share stimulus and are
// compared each cycle against a queue-based reference model of the decoded-instruction buffer.

module tb_decode_stage;
  import decode_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    opcode_t     op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
    logic [63:0] pc;
    logic [63:0] imm;
  } exp_t;

  typedef struct packed {
    logic valid;
    logic ready;
    exp_t e;
  } view_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc64;

  logic        o32_in_ready, o32_valid, o32_ill;
  logic [31:0] o32_pc, o32_imm;
  opcode_t     o32_op;
  logic [4:0]  o32_rs1, o32_rs2, o32_rd;
  logic [2:0]  o32_f3;
  logic [6:0]  o32_f7;

  logic        o64_in_ready, o64_valid, o64_ill;
  logic [63:0] o64_pc, o64_imm;
  opcode_t     o64_op;
  logic [4:0]  o64_rs1, o64_rs2, o64_rd;
  logic [2:0]  o64_f3;
  logic [6:0]  o64_f7;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH)) u_dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o32_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64[31:0]), .flush(flush), .out_valid(o32_valid),
    .out_ready(out_ready), .out_pc(o32_pc), .opcode(o32_op), .rs1(o32_rs1), .rs2(o32_rs2),
    .rd(o32_rd), .funct3(o32_f3), .funct7(o32_f7), .imm(o32_imm), .illegal(o32_ill)
  );

  decode_stage #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH)) u_dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o64_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .flush(flush), .out_valid(o64_valid),
    .out_ready(out_ready), .out_pc(o64_pc), .opcode(o64_op), .rs1(o64_rs1), .rs2(o64_rs2),
    .rd(o64_rd), .funct3(o64_f3), .funct7(o64_f7), .imm(o64_imm), .illegal(o64_ill)
  );

  // Reference decode: field extraction and immediates built from signed arithmetic.
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.f3  = ins[14:12];
    e.f7  = ins[31:25];
    case (ins[6:2])
      5'b00100: e.op = OP_IMM;
      5'b01100: e.op = OP;
      5'b00000: e.op = LOAD;
      5'b01000: e.op = STORE;
      5'b01101: e.op = LUI;
      5'b00101: e.op = AUIPC;
      5'b11011: e.op = JAL;
      5'b11001: e.op = JALR;
      5'b11000: e.op = BRANCH;
      default:  e.op = UNKNOWN;
    endcase
    if (ins[1:0] != 2'b11) e.op = UNKNOWN;
    case (e.op)
      OP_IMM, LOAD, JALR: e.imm = 64'($signed(ins[31:20]));
      STORE:       e.imm = 64'($signed({ins[31:25], ins[11:7]}));
      BRANCH:      e.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      LUI, AUIPC:  e.imm = 64'($signed(ins[31:12])) * 64'd4096;
      JAL:         e.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default:     e.imm = 64'd0;
    endcase
    e.ill = (e.op == UNKNOWN);
    return e;
  endfunction

  function automatic view_t exp_view(input bit is64);
    view_t v;
    v       = '0;
    v.e.op  = UNKNOWN;
    v.ready = (q.size() < DEPTH);
    if (q.size() != 0) begin
      v.valid = 1'b1;
      v.e     = q[0];
      if (!is64) begin
        v.e.pc  = {32'b0, q[0].pc[31:0]};
        v.e.imm = {32'b0, q[0].imm[31:0]};
      end
    end
    return v;
  endfunction

  function automatic view_t obs_view(input bit is64);
    view_t v;
    if (is64) begin
      v.valid = o64_valid; v.ready = o64_in_ready;
      v.e = '{op: o64_op, rs1: o64_rs1, rs2: o64_rs2, rd: o64_rd, f3: o64_f3, f7: o64_f7,
              ill: o64_ill, pc: o64_pc, imm: o64_imm};
    end else begin
      v.valid = o32_valid; v.ready = o32_in_ready;
      v.e = '{op: o32_op, rs1: o32_rs1, rs2: o32_rs2, rd: o32_rd, f3: o32_f3, f7: o32_f7,
              ill: o32_ill, pc: {32'b0, o32_pc}, imm: {32'b0, o32_imm}};
    end
    return v;
  endfunction

  // One clock: advance the model with the push/pop rules, then settle past the edge.
  task automatic step();
    int  n = q.size();
    bit  push = in_valid && (n < DEPTH) && !flush;
    bit  pop  = (n != 0) && out_ready && !flush;
    exp_t d   = model_decode(in_instr, in_pc64);
    @(posedge clk);
    if (reset || flush) q.delete();
    else begin
      if (pop)  q.delete(0);
      if (push) q.push_back(d);
    end
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    case ($urandom_range(0, 9))
      0: ins[6:2] = 5'b00100;  1: ins[6:2] = 5'b01100;
      2: ins[6:2] = 5'b00000;  3: ins[6:2] = 5'b01000;
      4: ins[6:2] = 5'b01101;  5: ins[6:2] = 5'b00101;
      6: ins[6:2] = 5'b11011;  7: ins[6:2] = 5'b11001;
      8: ins[6:2] = 5'b11000;  default: ins[6:2] = 5'b11111;
    endcase
    ins[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
    return ins;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc64 = '0;
    step(); step();
    reset = 1'b0;
    checks++;
    if (obs_view(0) !== exp_view(0)) begin
      errors++; $display("FAIL reset_view32: got %h expected %h", obs_view(0), exp_view(0));
    end
    checks++;
    if ({o32_valid, o32_in_ready, o32_op, o32_imm, o32_ill, o64_valid, o64_in_ready, o64_imm}
        !== {1'b0, 1'b1, UNKNOWN, 32'h0, 1'b0, 1'b0, 1'b1, 64'h0}) begin
      errors++; $display("FAIL reset_state: v32=%b r32=%b op=%0d imm32=%h v64=%b r64=%b imm64=%h",
                         o32_valid, o32_in_ready, o32_op, o32_imm, o64_valid, o64_in_ready, o64_imm);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] vec [3] = '{32'hFFF10093, 32'h00532423, 32'hFFDFF06F};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = vec[i]; in_pc64 = 64'h8000_0000 + 64'(4 * i);
      step();
      in_valid = 1'b0;
      checks++;
      if (obs_view(1) !== exp_view(1)) begin
        errors++; $display("FAIL vec%0d_view64: got %h expected %h", i, obs_view(1), exp_view(1));
      end
      checks++;
      case (i)
        0: if ({o32_valid, o32_op, o32_rd, o32_rs1, o32_f3, o32_imm, o32_ill}
               !== {1'b1, OP_IMM, 5'd1, 5'd2, 3'd0, 32'hFFFFFFFF, 1'b0}) begin
             errors++; $display("FAIL addi: v=%b op=%0d rd=%0d rs1=%0d f3=%0d imm=%h ill=%b",
                                o32_valid, o32_op, o32_rd, o32_rs1, o32_f3, o32_imm, o32_ill);
           end
        1: if ({o32_valid, o32_op, o32_rs1, o32_rs2, o32_f3, o32_imm}
               !== {1'b1, STORE, 5'd6, 5'd5, 3'd2, 32'h00000008}) begin
             errors++; $display("FAIL sw: v=%b op=%0d rs1=%0d rs2=%0d f3=%0d imm=%h",
                                o32_valid, o32_op, o32_rs1, o32_rs2, o32_f3, o32_imm);
           end
        default: if ({o32_op, o32_rd, o32_imm, o64_op, o64_imm, o64_pc}
                     !== {JAL, 5'd0, 32'hFFFFFFFC, JAL, 64'hFFFFFFFFFFFFFFFC, 64'h8000_0008}) begin
             errors++; $display("FAIL jal: op=%0d rd=%0d imm32=%h imm64=%h pc64=%h",
                                o32_op, o32_rd, o32_imm, o64_imm, o64_pc);
           end
      endcase
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs [3] = '{64'h100, 64'h204, 64'h308};
    logic [63:0] seen[$];
    bit accepted = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_pc64 = pcs[i];
      step();
    end
    checks++;
    if ({o32_in_ready, o32_valid, o32_pc} !== {1'b0, 1'b1, 32'h100}) begin
      errors++; $display("FAIL full_after_b: ready=%b valid=%b pc=%h", o32_in_ready, o32_valid, o32_pc);
    end
    in_instr = rand_instr(); in_pc64 = pcs[2];
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (o32_valid) seen.push_back({32'b0, o32_pc});
      if (in_valid && o32_in_ready) accepted = 1;
      step();
      if (accepted) in_valid = 1'b0;
      checks++;
      if (obs_view(0) !== exp_view(0)) begin
        errors++; $display("FAIL b2b_view32 cyc%0d: got %h expected %h", i, obs_view(0), exp_view(0));
      end
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== pcs[0] || seen[1] !== pcs[1] || seen[2] !== pcs[2]) begin
      errors++; $display("FAIL b2b_order: got %0d entries %p expected 100 204 308", seen.size(), seen);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_instr = rand_instr(); in_pc64 = 64'h40 + 64'(i);
      step();
    end
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc64 = 64'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if ({o32_valid, o32_in_ready, o64_valid, o64_in_ready} !== 4'b0101) begin
      errors++; $display("FAIL flush_state: v32=%b r32=%b v64=%b r64=%b",
                         o32_valid, o32_in_ready, o64_valid, o64_in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (o32_valid !== 1'b0 || o64_valid !== 1'b0) begin
        errors++; $display("FAIL flush_leak cyc%0d: v32=%b v64=%b pc=%h", i, o32_valid, o64_valid, o64_pc);
      end
    end
  endtask

  task automatic test_illegal_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0; in_pc64 = 64'h77;
    step();
    in_valid = 1'b0;
    checks++;
    if ({o32_valid, o32_ill, o32_op, o32_imm, o64_imm} !== {1'b1, 1'b1, UNKNOWN, 32'h0, 64'h0}) begin
      errors++; $display("FAIL illegal_zero: v=%b ill=%b op=%0d imm32=%h imm64=%h",
                         o32_valid, o32_ill, o32_op, o32_imm, o64_imm);
    end
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'h00532423;
    step();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if ({o32_valid, o32_in_ready, o32_ill, o32_pc, o64_valid} !== {1'b0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL reset_with_entry: v=%b r=%b ill=%b pc=%h v64=%b",
                         o32_valid, o32_in_ready, o32_ill, o32_pc, o64_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 49) == 0);
      in_instr  = rand_instr();
      in_pc64   = {$urandom, $urandom};
      step();
      checks++;
      if (obs_view(0) !== exp_view(0)) begin
        errors++; $display("FAIL rand32 cyc%0d: got %h expected %h", i, obs_view(0), exp_view(0));
      end
      checks++;
      if (obs_view(1) !== exp_view(1)) begin
        errors++; $display("FAIL rand64 cyc%0d: got %h expected %h", i, obs_view(1), exp_view(1));
      end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_flush();
    test_illegal_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
